// File: rtl/sia_pkg.sv
// -----------------------------------------------------------------------------
// sia_pkg
// Shared definitions for the SIA transmit path:
//   - sched_state_t : state encoding of the sia_tx_sched FSM
//   - START_BIT / STOP_FILL : framing constants (start bit, stop/idle fill)
//   - RESET_BAUD / RESET_BITS / RESET_TXCMOD : queue settings after reset
// -----------------------------------------------------------------------------
package sia_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,  // waiting for a request or a pending config
        S_PUSH  = 2'd1,  // settle cycle after a push so not_full_i catches up
        S_DRAIN = 2'd2   // no grants; waiting for the queue to empty out
    } sched_state_t;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_FILL = 1'b1;

    // 1 Mbps at 50 MHz, 8N1
    localparam int unsigned RESET_BAUD   = 49;
    localparam int unsigned RESET_BITS   = 10;
    localparam logic [2:0]  RESET_TXCMOD = 3'b100;

endpackage : sia_pkg

// File: rtl/sia_rr_arb2.sv
// -----------------------------------------------------------------------------
// sia_rr_arb2
// Two-way round-robin arbiter. The grant is combinational from req_i and the
// priority pointer; the pointer moves to the losing side when advance_i is
// high, so a requester that just won yields to the other one next time.
// Ports:
//   clk_i      in  1  clock, rising edge
//   reset_i    in  1  synchronous active-high reset (pointer -> requester 0)
//   req_i      in  2  request vector, bit 0 = A, bit 1 = B
//   advance_i  in  1  the current grant was taken; move the pointer
//   grant_o    out 2  one-hot grant (all zero when nobody requests)
// -----------------------------------------------------------------------------
module sia_rr_arb2 (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic [1:0] req_i,
    input  logic       advance_i,
    output logic [1:0] grant_o
);

    // 0: requester A has priority on a tie, 1: requester B has priority
    logic ptr_q;

    always_comb begin
        // NOTE: every path assigns grant_o, so no latch is inferred.
        grant_o = req_i;
        if (req_i == 2'b11) begin
            grant_o = ptr_q ? 2'b10 : 2'b01;
        end
    end

    // Pointer goes to the loser: if A won, B is favoured next, and vice versa.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ptr_q <= 1'b0;
        end else if (advance_i) begin
            ptr_q <= grant_o[0];
        end
    end

endmodule : sia_rr_arb2

// File: rtl/sia_tx_sched.sv
// -----------------------------------------------------------------------------
// sia_tx_sched
// Feeds one sia_txq transmit queue from two byte requesters (A, B).
// Arbitrates round-robin, frames each byte as {stop fill, data, start bit}
// (shifted out LSB first) and owns the queue's bits/baud/txcmod settings.
// New settings are written into a shadow and only applied once the queue has
// fully drained, so a character is never sent with mixed settings.
// Ports:
//   clk_i, reset_i              clock, synchronous active-high reset
//   cfg_we_i / cfg_*_i          write the config shadow (last write wins)
//   cfg_pending_o               shadow written but not yet applied
//   a_req_i/a_dat_i/a_ack_o     requester A handshake (ack = 1-cycle pulse)
//   b_req_i/b_dat_i/b_ack_o     requester B handshake
//   dat_o / we_o                framed word and push strobe to sia_txq
//   bits_o / baud_o / txcmod_o  live queue settings
//   not_full_i/empty_i/idle_i   sia_txq status
// All outputs are registered.
// -----------------------------------------------------------------------------
module sia_tx_sched #(
    parameter int unsigned SHIFT_REG_WIDTH = 12,  // min 10
    parameter int unsigned BAUD_RATE_WIDTH = 32,
    parameter int unsigned RESET_BAUD      = sia_pkg::RESET_BAUD,
    parameter int unsigned RESET_BITS      = sia_pkg::RESET_BITS,
    parameter logic [2:0]  RESET_TXCMOD    = sia_pkg::RESET_TXCMOD
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       cfg_we_i,
    input  logic [4:0]                 cfg_bits_i,
    input  logic [BAUD_RATE_WIDTH-1:0] cfg_baud_i,
    input  logic [2:0]                 cfg_txcmod_i,
    output logic                       cfg_pending_o,
    input  logic                       a_req_i,
    input  logic [7:0]                 a_dat_i,
    output logic                       a_ack_o,
    input  logic                       b_req_i,
    input  logic [7:0]                 b_dat_i,
    output logic                       b_ack_o,
    output logic [SHIFT_REG_WIDTH-1:0] dat_o,
    output logic                       we_o,
    output logic [4:0]                 bits_o,
    output logic [BAUD_RATE_WIDTH-1:0] baud_o,
    output logic [2:0]                 txcmod_o,
    input  logic                       not_full_i,
    input  logic                       empty_i,
    input  logic                       idle_i
);

    import sia_pkg::*;

    localparam int unsigned FILL_W = SHIFT_REG_WIDTH - 9;

    localparam logic [4:0]                 BITS_RST = 5'(RESET_BITS);
    localparam logic [BAUD_RATE_WIDTH-1:0] BAUD_RST = BAUD_RATE_WIDTH'(RESET_BAUD);

    sched_state_t state_q, state_d;

    logic [1:0] req;
    logic [1:0] grant;
    logic       arb_advance;

    logic                       we_d, a_ack_d, b_ack_d, pending_d, apply_cfg;
    logic [SHIFT_REG_WIDTH-1:0] dat_d;
    logic [7:0]                 win_byte;

    logic [4:0]                 shadow_bits_q;
    logic [BAUD_RATE_WIDTH-1:0] shadow_baud_q;
    logic [2:0]                 shadow_txcmod_q;

    assign req      = {b_req_i, a_req_i};
    assign win_byte = grant[1] ? b_dat_i : a_dat_i;

    sia_rr_arb2 u_arb (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .req_i     (req),
        .advance_i (arb_advance),
        .grant_o   (grant)
    );

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        we_d        = 1'b0;
        a_ack_d     = 1'b0;
        b_ack_d     = 1'b0;
        dat_d       = dat_o;
        arb_advance = 1'b0;
        apply_cfg   = 1'b0;

        case (state_q)
            S_IDLE: begin
                // A pending config blocks new grants so the queue can drain.
                if (cfg_pending_o) begin
                    state_d = S_DRAIN;
                end else if (not_full_i && (req != 2'b00)) begin
                    we_d        = 1'b1;
                    a_ack_d     = grant[0];
                    b_ack_d     = grant[1];
                    dat_d       = {{FILL_W{STOP_FILL}}, win_byte, START_BIT};
                    arb_advance = 1'b1;
                    state_d     = S_PUSH;
                end
            end
            S_PUSH: begin
                state_d = S_IDLE;
            end
            S_DRAIN: begin
                if (empty_i && idle_i) begin
                    apply_cfg = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A new write keeps the flag set even on the cycle an older one applies.
        pending_d = cfg_we_i ? 1'b1 : (apply_cfg ? 1'b0 : cfg_pending_o);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q       <= S_IDLE;
            we_o          <= 1'b0;
            a_ack_o       <= 1'b0;
            b_ack_o       <= 1'b0;
            cfg_pending_o <= 1'b0;
            dat_o         <= '1;
            bits_o        <= BITS_RST;
            baud_o        <= BAUD_RST;
            txcmod_o      <= RESET_TXCMOD;
        end else begin
            state_q       <= state_d;
            we_o          <= we_d;
            a_ack_o       <= a_ack_d;
            b_ack_o       <= b_ack_d;
            cfg_pending_o <= pending_d;
            dat_o         <= dat_d;
            if (apply_cfg) begin
                bits_o   <= shadow_bits_q;
                baud_o   <= shadow_baud_q;
                txcmod_o <= shadow_txcmod_q;
            end
        end
    end

    // Config shadow: loaded in any state, consumed only from S_DRAIN.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            shadow_bits_q   <= BITS_RST;
            shadow_baud_q   <= BAUD_RST;
            shadow_txcmod_q <= RESET_TXCMOD;
        end else if (cfg_we_i) begin
            shadow_bits_q   <= cfg_bits_i;
            shadow_baud_q   <= cfg_baud_i;
            shadow_txcmod_q <= cfg_txcmod_i;
        end
    end

endmodule : sia_tx_sched
